// File: rtl/alu_shift_ctl.sv
// Multi-cycle rotate/shift sequencer that drives alu_shifter_core for N cycles.
// Optional Z80 flag generation is enabled with `define ALU_SHIFT_FLAGS_EN.
module alu_shift_ctl #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [7:0]       operand,
  input  logic             cf_in,
  input  logic [CNT_W-1:0] count,
  output logic [7:0]       db,
  output logic             shift_in,
  output logic             shift_left,
  output logic             shift_right,
  input  logic             shift_db0,
  input  logic             shift_db7,
  input  logic [3:0]       out_high,
  input  logic [3:0]       out_low,
  output logic             busy,
  output logic             done,
  output logic [7:0]       result,
  output logic             cf_out,
  output logic [7:0]       flags_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_RLC = 3'd0,
    OP_RRC = 3'd1,
    OP_RL  = 3'd2,
    OP_RR  = 3'd3,
    OP_SLA = 3'd4,
    OP_SRA = 3'd5,
    OP_SLL = 3'd6,
    OP_SRL = 3'd7
  } op_t;

  // A zero count request means a full 2**CNT_W positions, so cnt is one bit wider.
  localparam logic [CNT_W:0] CNT_FULL = {1'b1, {CNT_W{1'b0}}};
  localparam logic [CNT_W:0] CNT_ONE  = {{CNT_W{1'b0}}, 1'b1};

  state_t         state_q, state_d;
  logic [7:0]     work_q, work_d;
  logic           wcy_q, wcy_d;
  logic [CNT_W:0] cnt_q, cnt_d;
  op_t            op_q, op_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [7:0]     result_q, result_d;
  logic           cf_out_q, cf_out_d;

  logic       shifting;
  logic       is_left;
  logic       accept;
  logic [7:0] core_out;
  logic       out_bit;
  logic       last_shift;

  assign shifting   = (state_q == S_SHIFT);
  assign is_left    = ~op_q[0];
  assign accept     = start && (state_q != S_SHIFT);
  assign core_out   = {out_high, out_low};
  assign out_bit    = is_left ? shift_db7 : shift_db0;
  assign last_shift = shifting && (cnt_q == CNT_ONE);

  assign db          = work_q;
  assign shift_left  = shifting &  is_left;
  assign shift_right = shifting & ~is_left;
  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign cf_out      = cf_out_q;

  always_comb begin
    shift_in = 1'b0;
    case (op_q)
      OP_RLC:       shift_in = shift_db7;
      OP_RRC:       shift_in = shift_db0;
      OP_RL, OP_RR: shift_in = wcy_q;
      OP_SLA:       shift_in = 1'b0;
      OP_SRA:       shift_in = shift_db7;
      OP_SLL:       shift_in = 1'b1;
      OP_SRL:       shift_in = 1'b0;
      default:      shift_in = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    wcy_d    = wcy_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    cf_out_d = cf_out_q;

    case (state_q)
      S_SHIFT: begin
        work_d = core_out;
        wcy_d  = out_bit;
        cnt_d  = cnt_q - CNT_ONE;
        if (last_shift) begin
          state_d  = S_DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = core_out;
          cf_out_d = out_bit;
        end
      end
      S_DONE: begin
        if (!start) state_d = S_IDLE;
      end
      default: ;
    endcase

    // Overrides IDLE/DONE behaviour; start is ignored while shifting.
    if (accept) begin
      state_d = S_SHIFT;
      work_d  = operand;
      wcy_d   = cf_in;
      cnt_d   = (count == '0) ? CNT_FULL : {1'b0, count};
      op_d    = op_t'(op);
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      work_q   <= 8'h00;
      wcy_q    <= 1'b0;
      cnt_q    <= '0;
      op_q     <= OP_RLC;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 8'h00;
      cf_out_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      wcy_q    <= wcy_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      cf_out_q <= cf_out_d;
    end
  end

`ifdef ALU_SHIFT_FLAGS_EN
  logic [7:0] flags_q, flags_d;

  // F = {S,Z,Y,H,X,P,N,C}; H and N are always cleared by rotate/shift ops.
  always_comb begin
    flags_d = flags_q;
    if (last_shift) begin
      flags_d = {core_out[7], (core_out == 8'h00), core_out[5], 1'b0,
                 core_out[3], ~^core_out, 1'b0, out_bit};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) flags_q <= 8'h00;
    else       flags_q <= flags_d;
  end

  assign flags_out = flags_q;
`else
  assign flags_out = 8'h00;
`endif

endmodule

// File: tb/tb_alu_shift_ctl.sv
// Directed bench for alu_shift_ctl with a behavioural alu_shifter_core alongside.
`timescale 1ns/1ps
module tb_alu_shift_ctl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] op = 3'd0;
  logic [7:0] operand = 8'h00;
  logic       cf_in = 1'b0;
  logic [2:0] count = 3'd0;
  logic [7:0] db;
  logic       shift_in, shift_left, shift_right;
  logic       shift_db0, shift_db7;
  logic [3:0] out_high, out_low;
  logic       busy, done, cf_out;
  logic [7:0] result, flags_out;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  alu_shift_ctl #(.CNT_W(3)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .operand(operand),
    .cf_in(cf_in), .count(count), .db(db), .shift_in(shift_in),
    .shift_left(shift_left), .shift_right(shift_right),
    .shift_db0(shift_db0), .shift_db7(shift_db7),
    .out_high(out_high), .out_low(out_low), .busy(busy), .done(done),
    .result(result), .cf_out(cf_out), .flags_out(flags_out)
  );

  // Shifter core: one position per cycle, pass-through when idle.
  logic [7:0] core_res;
  always_comb begin
    core_res = db;
    if (shift_left)       core_res = {db[6:0], shift_in};
    else if (shift_right) core_res = {shift_in, db[7:1]};
  end
  assign out_high  = core_res[7:4];
  assign out_low   = core_res[3:0];
  assign shift_db0 = db[0];
  assign shift_db7 = db[7];

  // Start sampled at edge 0; returns at the negedge after edge 0.
  task automatic launch(input logic [2:0] o, input logic [7:0] opd,
                        input logic c, input logic [2:0] n);
    @(negedge clk);
    start = 1'b1; op = o; operand = opd; cf_in = c; count = n;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vec_cnt++;
    if ({busy, done, cf_out, shift_left, shift_right} !== 5'b0) begin
      err_cnt++; $display("FAIL reset_ctl got=%b exp=00000", {busy, done, cf_out, shift_left, shift_right});
    end
    vec_cnt++;
    if ({result, db, flags_out} !== 24'h0) begin
      err_cnt++; $display("FAIL reset_data got=%h exp=000000", {result, db, flags_out});
    end
    reset = 1'b0;
  endtask

  task automatic test_rotate();
    int lat, bcnt;
    logic sl, sr;
    launch(3'd0, 8'h81, 1'b0, 3'd1);
    sl = shift_left; sr = shift_right;
    wait_done(lat, bcnt);
    vec_cnt++;
    if ({sl, sr} !== 2'b10) begin
      err_cnt++; $display("FAIL rlc_dir got=%b exp=10", {sl, sr});
    end
    vec_cnt++;
    if (lat !== 1 || bcnt !== 1) begin
      err_cnt++; $display("FAIL rlc_timing lat=%0d busy=%0d exp=1/1", lat, bcnt);
    end
    vec_cnt++;
    if (result !== 8'h03 || cf_out !== 1'b1) begin
      err_cnt++; $display("FAIL rlc_res got=%h/%b exp=03/1", result, cf_out);
    end
    launch(3'd3, 8'h01, 1'b1, 3'd1);
    sl = shift_left; sr = shift_right;
    wait_done(lat, bcnt);
    vec_cnt++;
    if ({sl, sr} !== 2'b01) begin
      err_cnt++; $display("FAIL rr_dir got=%b exp=01", {sl, sr});
    end
    vec_cnt++;
    if (result !== 8'h80 || cf_out !== 1'b1) begin
      err_cnt++; $display("FAIL rr_res got=%h/%b exp=80/1", result, cf_out);
    end
  endtask

  task automatic test_shift();
    int lat, bcnt;
    launch(3'd5, 8'h80, 1'b0, 3'd3);
    wait_done(lat, bcnt);
    vec_cnt++;
    if (result !== 8'hF0 || cf_out !== 1'b0 || lat !== 3) begin
      err_cnt++; $display("FAIL sra_res got=%h/%b lat=%0d exp=f0/0 lat=3", result, cf_out, lat);
    end
    launch(3'd6, 8'h00, 1'b1, 3'd2);
    wait_done(lat, bcnt);
    vec_cnt++;
    if (result !== 8'h03 || cf_out !== 1'b0) begin
      err_cnt++; $display("FAIL sll_res got=%h/%b exp=03/0", result, cf_out);
    end
    // done is a single-cycle pulse, result held afterwards
    @(negedge clk);
    vec_cnt++;
    if (done !== 1'b0 || result !== 8'h03) begin
      err_cnt++; $display("FAIL done_pulse done=%b res=%h exp=0/03", done, result);
    end
  endtask

  task automatic test_rl9();
    int lat, bcnt;
    launch(3'd2, 8'h80, 1'b0, 3'd0);
    wait_done(lat, bcnt);
    vec_cnt++;
    if (lat !== 8 || bcnt !== 8) begin
      err_cnt++; $display("FAIL rl8_timing lat=%0d busy=%0d exp=8/8", lat, bcnt);
    end
    vec_cnt++;
    if (result !== 8'h40 || cf_out !== 1'b0) begin
      err_cnt++; $display("FAIL rl8_res got=%h/%b exp=40/0", result, cf_out);
    end
  endtask

  task automatic test_ignore_start();
    int lat, bcnt;
    launch(3'd7, 8'hFF, 1'b0, 3'd4);
    @(negedge clk);
    start = 1'b1; op = 3'd0; operand = 8'h00; cf_in = 1'b1; count = 3'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bcnt);
    vec_cnt++;
    if (lat !== 2) begin
      err_cnt++; $display("FAIL ign_lat got=%0d exp=2", lat);
    end
    vec_cnt++;
    if (result !== 8'h0F || cf_out !== 1'b1) begin
      err_cnt++; $display("FAIL ign_res got=%h/%b exp=0f/1", result, cf_out);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt;
    launch(3'd7, 8'hFF, 1'b0, 3'd1);
    wait_done(lat, bcnt);
    start = 1'b1; op = 3'd0; operand = 8'h81; cf_in = 1'b0; count = 3'd1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    vec_cnt++;
    if (busy !== 1'b1 || done !== 1'b0 || shift_left !== 1'b1) begin
      err_cnt++; $display("FAIL b2b_gap busy=%b done=%b sl=%b exp=1/0/1", busy, done, shift_left);
    end
    wait_done(lat, bcnt);
    vec_cnt++;
    if (lat !== 1 || result !== 8'h03 || cf_out !== 1'b1) begin
      err_cnt++; $display("FAIL b2b_res lat=%0d got=%h/%b exp=1 03/1", lat, result, cf_out);
    end
  endtask

  task automatic test_abort();
    int seen = 0;
    launch(3'd7, 8'hFF, 1'b0, 3'd4);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vec_cnt++;
    if ({busy, done, cf_out} !== 3'b0 || result !== 8'h00 || db !== 8'h00) begin
      err_cnt++; $display("FAIL abort_state b/d/c=%b res=%h db=%h exp=000 00 00", {busy, done, cf_out}, result, db);
    end
    repeat (10) begin
      @(negedge clk);
      if (done) seen++;
    end
    vec_cnt++;
    if (seen !== 0) begin
      err_cnt++; $display("FAIL abort_done got=%0d exp=0", seen);
    end
  endtask

  task automatic test_flags();
    int lat, bcnt;
    logic [7:0] exp_fl;
`ifdef ALU_SHIFT_FLAGS_EN
    exp_fl = 8'h45;
`else
    exp_fl = 8'h00;
`endif
    launch(3'd7, 8'h01, 1'b0, 3'd1);
    wait_done(lat, bcnt);
    vec_cnt++;
    if (result !== 8'h00 || cf_out !== 1'b1) begin
      err_cnt++; $display("FAIL flags_res got=%h/%b exp=00/1", result, cf_out);
    end
    vec_cnt++;
    if (flags_out !== exp_fl) begin
      err_cnt++; $display("FAIL flags_out got=%h exp=%h", flags_out, exp_fl);
    end
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_shift();
    test_rl9();
    test_ignore_start();
    test_back_to_back();
    test_abort();
    test_flags();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/alu_shift_ctl.md
Name: alu_shift_ctl

Overview:
- Multi-cycle sequencer that sits directly upstream of alu_shifter_core.
- Latches an 8-bit operand and a Z80 rotate/shift opcode, then drives the core's db, shift_in, shift_left and shift_right for N consecutive cycles.
- Each cycle it recaptures {out_high,out_low} and tracks the outgoing carry bit.
- Returns the final byte, carry and (optionally) Z80 flags to the ALU datapath through a start/done handshake.

Parameters:
- CNT_W, 3, width of shift-count input; count value 0 means 2**CNT_W positions (8).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- start  in  1  request; sampled in IDLE or DONE only
- op  in  3  0 RLC, 1 RRC, 2 RL, 3 RR, 4 SLA, 5 SRA, 6 SLL, 7 SRL
- operand  in  8  byte to shift
- cf_in  in  1  carry flag entering the operation
- count  in  CNT_W  positions to shift (0 = 8)
- db  out  8  to core db (= work register)
- shift_in  out  1  to core shift_in
- shift_left  out  1  to core shift_left
- shift_right  out  1  to core shift_right
- shift_db0  in  1  from core, db[0]
- shift_db7  in  1  from core, db[7]
- out_high  in  4  from core, result high nibble
- out_low  in  4  from core, result low nibble
- busy  out  1  high while shifting
- done  out  1  one-cycle pulse, result valid
- result  out  8  final byte, held until next accepted start
- cf_out  out  1  final carry, held with result
- flags_out  out  8  Z80 F layout {S,Z,Y,H,X,P,N,C}

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (reset); all registers are updated on the rising clk edge.
- Reset values: state=IDLE, work=0x00, wcy=0, cnt=0, busy=0, done=0, result=0x00, cf_out=0, flags_out=0x00.
- Reset mid-operation aborts immediately; no done pulse is generated.
- States:
  - IDLE -> SHIFT on start.
  - SHIFT -> SHIFT while cnt>1; SHIFT -> DONE when cnt==1.
  - DONE -> IDLE, or DONE -> SHIFT if start is asserted in DONE (back-to-back operation).
- Start-accept edge: work<=operand, wcy<=cf_in, cnt<=count (0 maps to 8), opcode latched.
- start during SHIFT is ignored. operand, op, cf_in and count are not re-sampled while busy.
- Core drive:
  - db=work in all states.
  - shift_left=1 in SHIFT for ops 0,2,4,6; shift_right=1 in SHIFT for ops 1,3,5,7.
  - Both are 0 outside SHIFT, so the core passes data through. They are never both 1.
- shift_in selection:
  - RLC: shift_db7; RRC: shift_db0.
  - RL, RR: wcy.
  - SLA: 0; SRA: shift_db7; SLL: 1; SRL: 0.
- Each SHIFT edge: work<={out_high,out_low}; wcy<=shift_db7 for left ops, shift_db0 for right ops; cnt<=cnt-1.
- Latency: start sampled at edge 0, shifts at edges 1..N. done=1 and busy=0 in the cycle after edge N. busy=1 from after edge 0 through edge N.
- result and cf_out: registered at edge N (from core output and outgoing bit), stable from the done cycle until the next accepted start.
- RL/RR with N=8 behave as a 9-bit rotate through carry.

Optional Feature:
- Macro: ALU_SHIFT_FLAGS_EN.
- Defined: at edge N, flags_out is registered as:
  - S=result[7]; Z=(result==0); Y=result[5]; X=result[3]
  - H=0; N=0; P=even parity of result; C=cf_out
- Undefined: flags_out is tied to 0x00 and no flag logic is synthesised. Bit 0 is still cf_out via the cf_out port only.

Test Plan:
- RLC, operand 0x81, cf_in 0, count 1 -> done in cycle 2 after start; result 0x03, cf_out 1; busy high exactly 1 cycle.
- RR, operand 0x01, cf_in 1, count 1 -> result 0x80, cf_out 1. SRA, 0x80, count 3 -> result 0xF0, cf_out 0.
- RL, operand 0x80, cf_in 0, count 0 (8 positions) -> result 0x40, cf_out 0, done 9 cycles after start. SLL, 0x00, count 2 -> 0x03, cf_out 0.
- SRL 0xFF count 4, with start re-asserted during SHIFT -> second start ignored; result 0x0F, cf_out 1. start held in DONE -> new operation begins the next cycle with no IDLE gap.
- SRL 0xFF count 4, reset asserted after 2 SHIFT cycles -> next cycle busy 0, done 0, result 0x00, cf_out 0, db 0x00, no later done.
- With ALU_SHIFT_FLAGS_EN, SRL 0x01 count 1 -> result 0x00, flags_out 0x45 (Z, P, C). Without the macro -> flags_out 0x00.
